// File: rtl/clint_interrupt_source.sv
// Machine timer/software interrupt source: MSIP, MTIMECMP and a free-running MTIME
// behind a single-cycle register bus, raising req/ack interrupt requests on condition edges.
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module clint_interrupt_source #(
    parameter int unsigned PRESCALE   = 1,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      bus_addr,
    input  logic                       bus_wr,
    input  logic [`REG_DATA_WIDTH-1:0] bus_wdata,
    input  logic                       bus_rd,
    output logic [31:0]                bus_rdata,
    output logic                       all_intif_int_timer_req,
    output logic                       all_intif_int_software_req,
    input  logic                       intif_all_int_timer_ack,
    input  logic                       intif_all_int_software_ack
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MSIP     = ADDR_WIDTH'(16'h0000);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CMP_LO   = ADDR_WIDTH'(16'h4000);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CMP_HI   = ADDR_WIDTH'(16'h4004);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MTIME_LO = ADDR_WIDTH'(16'hBFF8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MTIME_HI = ADDR_WIDTH'(16'hBFFC);
    localparam logic [PW-1:0]         PRESC_LAST    = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          tcond_q, tcond_d;
    logic          scond_q, scond_d;
    logic          timer_pend_q, timer_pend_d;
    logic          sw_pend_q, sw_pend_d;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  tick;
    logic                  timer_cond;
    logic                  sw_cond;

    // Low address bits are masked rather than dropped so every address bit is consumed.
    assign word_addr  = bus_addr & ~ADDR_WIDTH'(3);
    assign tick       = (presc_q == PRESC_LAST);
    assign timer_cond = (mtime_q >= mtimecmp_q);
    assign sw_cond    = msip_q;

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PW'(1);
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = mtime_q;
        rdata_d    = rdata_q;

        if (bus_rd) begin
            if (word_addr == ADDR_MSIP)          rdata_d = {31'b0, msip_q};
            else if (word_addr == ADDR_CMP_LO)   rdata_d = mtimecmp_q[31:0];
            else if (word_addr == ADDR_CMP_HI)   rdata_d = mtimecmp_q[63:32];
            else if (word_addr == ADDR_MTIME_LO) rdata_d = mtime_q[31:0];
            else if (word_addr == ADDR_MTIME_HI) rdata_d = mtime_q[63:32];
            else                                 rdata_d = 32'b0;
        end

        if (bus_wr && word_addr == ADDR_MSIP)   msip_d = bus_wdata[0];
        if (bus_wr && word_addr == ADDR_CMP_LO) mtimecmp_d[31:0] = bus_wdata;
        if (bus_wr && word_addr == ADDR_CMP_HI) mtimecmp_d[63:32] = bus_wdata;

        // An MTIME write of either half freezes the whole counter for that edge.
        if (bus_wr && word_addr == ADDR_MTIME_LO)      mtime_d[31:0] = bus_wdata;
        else if (bus_wr && word_addr == ADDR_MTIME_HI) mtime_d[63:32] = bus_wdata;
        else if (tick)                                 mtime_d = mtime_q + 64'd1;
    end

    always_comb begin
        tcond_d      = timer_cond;
        scond_d      = sw_cond;
        timer_pend_d = timer_pend_q;
        sw_pend_d    = sw_pend_q;

        // A fresh rising condition outranks an ack arriving on the same edge.
        if (timer_cond && !tcond_q)        timer_pend_d = 1'b1;
        else if (intif_all_int_timer_ack)  timer_pend_d = 1'b0;

        if (sw_cond && !scond_q)              sw_pend_d = 1'b1;
        else if (intif_all_int_software_ack)  sw_pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q      <= '0;
            mtime_q      <= 64'd0;
            mtimecmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q       <= 1'b0;
            rdata_q      <= 32'd0;
            tcond_q      <= 1'b0;
            scond_q      <= 1'b0;
            timer_pend_q <= 1'b0;
            sw_pend_q    <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            msip_q       <= msip_d;
            rdata_q      <= rdata_d;
            tcond_q      <= tcond_d;
            scond_q      <= scond_d;
            timer_pend_q <= timer_pend_d;
            sw_pend_q    <= sw_pend_d;
        end
    end

    assign bus_rdata                  = rdata_q;
    assign all_intif_int_timer_req    = timer_pend_q;
    assign all_intif_int_software_req = sw_pend_q;

endmodule

// File: tb/tb_clint_interrupt_source.sv
// Bench for clint_interrupt_source: two instances (PRESCALE 1 and 4) share one bus and
// are compared every cycle against a register-level model, plus directed latency/boundary steps.
module tb_clint_interrupt_source;

    logic        clk;
    logic        rst;
    logic [15:0] bus_addr;
    logic        bus_wr;
    logic [31:0] bus_wdata;
    logic        bus_rd;
    logic        tack;
    logic        sack;

    logic [31:0] rdata [2];
    logic        treq  [2];
    logic        sreq  [2];

    int checks;
    int failures;

    clint_interrupt_source #(.PRESCALE(1), .ADDR_WIDTH(16)) dut_p1 (
        .clk                        (clk),
        .rst                        (rst),
        .bus_addr                   (bus_addr),
        .bus_wr                     (bus_wr),
        .bus_wdata                  (bus_wdata),
        .bus_rd                     (bus_rd),
        .bus_rdata                  (rdata[0]),
        .all_intif_int_timer_req    (treq[0]),
        .all_intif_int_software_req (sreq[0]),
        .intif_all_int_timer_ack    (tack),
        .intif_all_int_software_ack (sack)
    );

    clint_interrupt_source #(.PRESCALE(4), .ADDR_WIDTH(16)) dut_p4 (
        .clk                        (clk),
        .rst                        (rst),
        .bus_addr                   (bus_addr),
        .bus_wr                     (bus_wr),
        .bus_wdata                  (bus_wdata),
        .bus_rd                     (bus_rd),
        .bus_rdata                  (rdata[1]),
        .all_intif_int_timer_req    (treq[1]),
        .all_intif_int_software_req (sreq[1]),
        .intif_all_int_timer_ack    (tack),
        .intif_all_int_software_ack (sack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-level reference: architectural registers plus the request bookkeeping.
    int unsigned presc [2] = '{1, 4};
    logic [63:0] m_time  [2];
    logic [63:0] m_cmp   [2];
    logic        m_msip  [2];
    logic        m_tprev [2];
    logic        m_sprev [2];
    logic        m_tp    [2];
    logic        m_sp    [2];
    logic [31:0] m_rdata [2];
    int unsigned m_cyc   [2];

    function automatic logic [31:0] model_read(input int k, input logic [15:0] a);
        logic [15:0] w;
        w = a & 16'hFFFC;
        case (w)
            16'h0000: return {31'b0, m_msip[k]};
            16'h4000: return m_cmp[k][31:0];
            16'h4004: return m_cmp[k][63:32];
            16'hBFF8: return m_time[k][31:0];
            16'hBFFC: return m_time[k][63:32];
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic        tc;
        logic        sc;
        logic [15:0] w;
        w = bus_addr & 16'hFFFC;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_time[k]  = 64'd0;
                m_cmp[k]   = 64'hFFFF_FFFF_FFFF_FFFF;
                m_msip[k]  = 1'b0;
                m_tprev[k] = 1'b0;
                m_sprev[k] = 1'b0;
                m_tp[k]    = 1'b0;
                m_sp[k]    = 1'b0;
                m_rdata[k] = 32'd0;
                m_cyc[k]   = 0;
            end else begin
                tc = (m_time[k] >= m_cmp[k]);
                sc = m_msip[k];
                if (bus_rd) m_rdata[k] = model_read(k, bus_addr);
                m_tp[k] = (tc && !m_tprev[k]) || (m_tp[k] && !tack);
                m_sp[k] = (sc && !m_sprev[k]) || (m_sp[k] && !sack);
                m_tprev[k] = tc;
                m_sprev[k] = sc;
                if (bus_wr && w == 16'hBFF8)      m_time[k][31:0]  = bus_wdata;
                else if (bus_wr && w == 16'hBFFC) m_time[k][63:32] = bus_wdata;
                else if (m_cyc[k] % presc[k] == presc[k] - 1) m_time[k] = m_time[k] + 64'd1;
                m_cyc[k] = m_cyc[k] + 1;
                if (bus_wr && w == 16'h0000) m_msip[k] = bus_wdata[0];
                if (bus_wr && w == 16'h4000) m_cmp[k][31:0]  = bus_wdata;
                if (bus_wr && w == 16'h4004) m_cmp[k][63:32] = bus_wdata;
            end
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] a, input logic wr, input logic [31:0] wd,
                                  input logic rd, input logic ta, input logic sa);
        bus_addr  = a;
        bus_wr    = wr;
        bus_wdata = wd;
        bus_rd    = rd;
        tack      = ta;
        sack      = sa;
        @(posedge clk);
        model_edge();
        #1;
        check_output("rdata_p1", rdata[0], m_rdata[0]);
        check_output("rdata_p4", rdata[1], m_rdata[1]);
        check_output("treq_p1", {31'b0, treq[0]}, {31'b0, m_tp[0]});
        check_output("treq_p4", {31'b0, treq[1]}, {31'b0, m_tp[1]});
        check_output("sreq_p1", {31'b0, sreq[0]}, {31'b0, m_sp[0]});
        check_output("sreq_p4", {31'b0, sreq[1]}, {31'b0, m_sp[1]});
    endtask

    task automatic idle();
        apply_stimulus(16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [31:0] d);
        apply_stimulus(a, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd_reg(input logic [15:0] a);
        apply_stimulus(a, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        apply_stimulus(16'h0000, 1'b1, 32'h1, 1'b1, 1'b1, 1'b1);
        apply_stimulus(16'hBFF8, 1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
    endtask

    task automatic wait_mtime_p1(input logic [63:0] target, input string tag);
        int n;
        n = 0;
        while (m_time[0] != target && n < 200) begin
            idle();
            n++;
        end
        check_output(tag, {31'b0, m_time[0] == target}, 32'd1);
    endtask

    initial begin
        logic [15:0] addrs [8] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8,
                                   16'hBFFC, 16'h1234, 16'h0004, 16'h4002};
        logic [15:0] a;
        logic [31:0] d;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;

        // Reset with stimulus active, then counting from 0.
        do_reset();
        rd_reg(16'hBFF8);
        check_output("mtime_lo_first", rdata[0], 32'd0);
        check_output("mtime_lo_first_p4", rdata[1], 32'd0);
        check_output("treq_after_rst", {31'b0, treq[0]}, 32'd0);
        check_output("sreq_after_rst", {31'b0, sreq[0]}, 32'd0);
        rd_reg(16'hBFF8);
        check_output("mtime_lo_second", rdata[0], 32'd1);
        rd_reg(16'hBFFC);
        check_output("mtime_hi_reset", rdata[0], 32'd0);
        rd_reg(16'h4004);
        check_output("cmp_hi_reset", rdata[0], 32'hFFFF_FFFF);

        // Software interrupt: latency, ack, no re-request, re-arm.
        wr_reg(16'h0000, 32'h1);
        check_output("sw_req_not_yet", {31'b0, sreq[0]}, 32'd0);
        idle();
        check_output("sw_req_rise", {31'b0, sreq[0]}, 32'd1);
        idle();
        check_output("sw_req_held", {31'b0, sreq[0]}, 32'd1);
        apply_stimulus(16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_output("sw_req_acked", {31'b0, sreq[0]}, 32'd0);
        idle();
        idle();
        check_output("sw_no_rereq", {31'b0, sreq[0]}, 32'd0);
        wr_reg(16'h0000, 32'h0);
        idle();
        wr_reg(16'h0000, 32'h1);
        idle();
        check_output("sw_rearm", {31'b0, sreq[0]}, 32'd1);
        apply_stimulus(16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Set and ack on the same edge keeps the request; stray acks do nothing.
        wr_reg(16'h0000, 32'h0);
        idle();
        wr_reg(16'h0000, 32'h1);
        apply_stimulus(16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_output("sw_set_beats_ack", {31'b0, sreq[0]}, 32'd1);
        apply_stimulus(16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(16'h0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check_output("stray_ack_sw", {31'b0, sreq[0]}, 32'd0);
        check_output("stray_ack_timer", {31'b0, treq[0]}, 32'd0);

        // Timer interrupt at MTIME == 20, then re-armed at 40.
        do_reset();
        idle();
        wr_reg(16'h4004, 32'h0);
        wr_reg(16'h4000, 32'd20);
        wait_mtime_p1(64'd20, "reach_mtime20");
        check_output("timer_not_yet", {31'b0, treq[0]}, 32'd0);
        idle();
        check_output("timer_rise_20", {31'b0, treq[0]}, 32'd1);
        apply_stimulus(16'h0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_output("timer_acked", {31'b0, treq[0]}, 32'd0);
        idle();
        idle();
        check_output("timer_no_rereq", {31'b0, treq[0]}, 32'd0);
        wr_reg(16'h4000, 32'hFFFF_FFFF);
        wr_reg(16'h4004, 32'hFFFF_FFFF);
        wr_reg(16'h4004, 32'h0);
        wr_reg(16'h4000, 32'd40);
        wait_mtime_p1(64'd40, "reach_mtime40");
        idle();
        check_output("timer_rise_40", {31'b0, treq[0]}, 32'd1);
        apply_stimulus(16'h0000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Prescaled counting seen through back-to-back reads.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            rd_reg(16'hBFF8);
            check_output("presc1_count", rdata[0], 32'(i));
            check_output("presc4_count", rdata[1], 32'(i / 4));
        end

        // Read-while-write returns the old value, then the new one; unmapped reads 0.
        apply_stimulus(16'hBFF8, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        rd_reg(16'hBFF8);
        check_output("rw_new_p1", rdata[0], 32'h1234_5678);
        check_output("rw_new_p4", rdata[1], 32'h1234_5678);
        rd_reg(16'h1234);
        check_output("unmapped_p1", rdata[0], 32'h0);
        check_output("unmapped_p4", rdata[1], 32'h0);

        // 64-bit wrap of MTIME.
        wr_reg(16'hBFF8, 32'hFFFF_FFFF);
        wr_reg(16'hBFFC, 32'hFFFF_FFFF);
        idle();
        rd_reg(16'hBFF8);
        check_output("wrap_lo", rdata[0], 32'h0);
        rd_reg(16'hBFFC);
        check_output("wrap_hi", rdata[0], 32'h0);
        for (int i = 0; i < 4; i++) idle();
        rd_reg(16'hBFFC);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            a = addrs[$urandom_range(0, 7)];
            case (a & 16'hFFFC)
                16'h0000: d = {31'b0, 1'($urandom_range(0, 1))};
                16'h4000: d = $urandom_range(0, 500);
                16'h4004: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'h0;
                16'hBFF8: d = $urandom_range(0, 300);
                default:  d = $urandom;
            endcase
            rst = ($urandom_range(0, 99) != 0);
            apply_stimulus(a, ($urandom_range(0, 9) < 3), d, ($urandom_range(0, 1) == 1),
                           ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
        end
        rst = 1'b1;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
